// File: rtl/mc_control_unit_if.sv
// Control-unit bus bundle: IR fields, ALU flags and the memory handshake in,
// datapath enables and multiplexer selects out.
//   slave  : the control unit (consumes decode inputs, drives controls)
//   master : the datapath / test driver (drives decode inputs, observes controls)
interface mc_control_unit_if;
  // Decode and status inputs to the control unit
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       ZF;
  logic       SF;
  logic       CF;
  logic       OF;
  logic       mem_ready;

  // Datapath controls from the control unit
  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       illegal;
  logic [3:0] state;

  modport slave (
    input  op, funct3, funct7_5, ZF, SF, CF, OF, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, illegal, state
  );

  modport master (
    output op, funct3, funct7_5, ZF, SF, CF, OF, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, illegal, state
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit for a shared-memory datapath.
// Sequences fetch/decode/execute/writeback, stalls on mem_ready, and flags
// unsupported instructions with a sticky illegal state.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (returns to FETCH, clears illegal)
//   bus  - mc_control_unit_if.slave: IR fields, ALU flags, mem_ready in;
//          write enables, mux selects, ALUControl, illegal, debug state out
// Parameters:
//   EN_BRANCH_EXT - decode BGE/BLTU/BGEU
//   EN_JUMP       - decode JAL/JALR/LUI
module mc_control_unit #(
  parameter bit EN_BRANCH_EXT = 1'b1,
  parameter bit EN_JUMP       = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  mc_control_unit_if.slave   bus
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 4;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [ALU_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SLL   = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_SUB   = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SLT   = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_XOR   = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SRL   = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_OR    = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_AND   = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SRA   = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_PASSB = 4'b1111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_ILLEGAL  = 4'd15
  } state_e;

  state_e state_q, state_d;

  // ALU operation from funct3; SUB only for register-register, SRA for both forms
  function automatic logic [ALU_W-1:0] alu_dec(input logic [2:0] f3,
                                               input logic       f7,
                                               input logic       is_r);
    logic [ALU_W-1:0] res;
    case (f3)
      3'b000:  res = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  res = ALU_SLL;
      3'b010:  res = ALU_SLT;
      3'b011:  res = ALU_SLTU;
      3'b100:  res = ALU_XOR;
      3'b101:  res = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  res = ALU_OR;
      default: res = ALU_AND;
    endcase
    return res;
  endfunction

  logic branch_ok_c;
  logic branch_taken_c;

  // Supported branch funct3 values; extended compares depend on EN_BRANCH_EXT
  always_comb begin
    branch_ok_c = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b100: branch_ok_c = 1'b1;
      3'b101, 3'b110, 3'b111: branch_ok_c = EN_BRANCH_EXT;
      default:                branch_ok_c = 1'b0;
    endcase
  end

  // Branch condition from the rs1 - rs2 flags; CF=1 means no borrow
  always_comb begin
    branch_taken_c = 1'b0;
    case (bus.funct3)
      3'b000:  branch_taken_c = bus.ZF;
      3'b001:  branch_taken_c = ~bus.ZF;
      3'b100:  branch_taken_c = bus.SF ^ bus.OF;
      3'b101:  branch_taken_c = ~(bus.SF ^ bus.OF);
      3'b110:  branch_taken_c = ~bus.CF;
      3'b111:  branch_taken_c = bus.CF;
      default: branch_taken_c = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_B:         state_d = branch_ok_c ? S_BRANCH : S_ILLEGAL;
          OP_JAL:       state_d = EN_JUMP ? S_JAL : S_ILLEGAL;
          OP_JALR:      state_d = EN_JUMP ? S_JALR1 : S_ILLEGAL;
          OP_LUI:       state_d = EN_JUMP ? S_LUI : S_ILLEGAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR1:    state_d = S_JALR2;
      S_JALR2:    state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  logic             pc_write_c;
  logic             ir_write_c;
  logic             reg_write_c;
  logic             mem_write_c;
  logic             adr_src_c;
  logic [1:0]       alu_src_a_c;
  logic [1:0]       alu_src_b_c;
  logic [1:0]       result_src_c;
  logic [2:0]       imm_src_c;
  logic [ALU_W-1:0] alu_ctrl_c;

  // Output decode from state and IR fields; enables gated off during reset
  always_comb begin
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    result_src_c = 2'b00;
    imm_src_c    = 3'b000;
    alu_ctrl_c   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = bus.mem_ready;
        pc_write_c   = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        imm_src_c   = (bus.op == OP_JAL) ? 3'b011 : 3'b010;
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        imm_src_c   = (bus.op == OP_SW) ? 3'b001 : 3'b000;
      end
      S_MEMREAD:  adr_src_c = 1'b1;
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_c = 2'b10;
        alu_ctrl_c  = alu_dec(bus.funct3, bus.funct7_5, 1'b1);
      end
      S_EXECI: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_ctrl_c  = alu_dec(bus.funct3, bus.funct7_5, 1'b0);
      end
      S_ALUWB:    reg_write_c = 1'b1;
      S_BRANCH: begin
        alu_src_a_c = 2'b10;
        alu_ctrl_c  = ALU_SUB;
        pc_write_c  = branch_taken_c;
      end
      // rd <= OldPC + 4 while PC takes the target already held in ALUOut
      S_JAL, S_JALR2: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
      end
      S_JALR1: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
      end
      S_LUI: begin
        alu_src_b_c = 2'b01;
        imm_src_c   = 3'b100;
        alu_ctrl_c  = ALU_PASSB;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write_c  = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      mem_write_c = 1'b0;
    end
  end

  assign bus.PCWrite    = pc_write_c;
  assign bus.IRWrite    = ir_write_c;
  assign bus.RegWrite   = reg_write_c;
  assign bus.MemWrite   = mem_write_c;
  assign bus.AdrSrc     = adr_src_c;
  assign bus.ALUSrcA    = alu_src_a_c;
  assign bus.ALUSrcB    = alu_src_b_c;
  assign bus.ResultSrc  = result_src_c;
  assign bus.ImmSrc     = imm_src_c;
  assign bus.ALUControl = alu_ctrl_c;
  assign bus.illegal    = (state_q == S_ILLEGAL);
  assign bus.state      = STATE_W'(state_q);

endmodule
